// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (iterative double-dabble, one bit per clock).
// Produces packed BCD digits for the seven-segment decoders, a leading-zero
// blanking mask, and a saturating overflow flag for values that do not fit.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank,
  output logic                  overflow
);

  localparam int SW    = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  // Largest value representable in DIGITS decimal digits, fixed at elaboration.
  function automatic longint unsigned max_value(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p - 1;
  endfunction

  localparam longint unsigned MAX_VAL = max_value(DIGITS);

  typedef enum logic {IDLE, CONV} state_t;

  state_t              state_q, state_d;
  logic [BIN_W-1:0]    shift_q, shift_d;
  logic [SW-1:0]       scratch_q, scratch_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_pend_q, ovf_pend_d;
  logic [SW-1:0]       bcd_q, bcd_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic                overflow_q, overflow_d;
  logic                done_q, done_d;

  logic [SW-1:0]       adj;
  logic [SW-1:0]       scratch_shift;
  logic [SW-1:0]       result;
  logic [DIGITS-1:0]   blank_calc;
  logic                bin_too_big;

  // Add-3 correction on every digit in parallel before the shift.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
    assign adj[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5) ? scratch_q[4*gi +: 4] + 4'd3
                                                          : scratch_q[4*gi +: 4];
  end

  // Scratch MSB is dropped on the shift; that only happens for saturated values.
  assign scratch_shift = {adj[SW-2:0], shift_q[BIN_W-1]};
  assign result        = ovf_pend_q ? {DIGITS{4'h9}} : scratch_shift;
  assign bin_too_big   = (64'(bin) > MAX_VAL);

  // Digit i is blanked when it and every more significant digit are zero.
  assign blank_calc[0] = 1'b0;
  for (genvar gi = 1; gi < DIGITS; gi++) begin : g_blank
    assign blank_calc[gi] = (result[SW-1:4*gi] == '0);
  end

  // State register; reset aborts any conversion without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      blank_q    <= {{(DIGITS-1){1'b1}}, 1'b0};
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      blank_q    <= blank_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic: capture in IDLE, one double-dabble step per CONV cycle.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    blank_d    = blank_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d    = bin;
          scratch_d  = '0;
          cnt_d      = CNT_W'(BIN_W);
          ovf_pend_d = bin_too_big;
          state_d    = CONV;
        end
      end
      CONV: begin
        scratch_d = scratch_shift;
        shift_d   = shift_q << 1;
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          bcd_d      = result;
          blank_d    = blank_calc;
          overflow_d = ovf_pend_q;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == CONV);
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign blank    = blank_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: reset, latency, values, boundaries,
// ignored starts, back-to-back stepping and a random sweep against a decimal model.
module tb_bin_to_bcd_seq;

  localparam int BIN_W  = 14;
  localparam int DIGITS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [13:0] bin = '0;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic [3:0]  blank;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .blank(blank), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference: plain decimal arithmetic with saturation above 9999.
  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r;
    int t;
    if (v > 9999) return 16'h9999;
    t = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] ref_blank(input int v);
    logic [3:0] r;
    int p;
    r = '0;
    if (v > 9999) return r;
    p = 1;
    for (int i = 1; i < 4; i++) begin
      p = p * 10;
      r[i] = (v < p);
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input int v);
    return (v > 9999);
  endfunction

  function automatic int rand_val();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(9990, 10010));
    return int'($urandom_range(0, 16383));
  endfunction

  // Drives one conversion from a negedge; returns results, latency and busy count.
  task automatic run_conv(input int v, output logic [15:0] o_bcd, output logic [3:0] o_blank,
                          output logic o_ovf, output int lat, output int busy_cnt, output bit timeout);
    start = 1'b1;
    bin = 14'(v);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    bin = 14'($urandom);
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    timeout = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done) begin
        timeout = 1'b0;
        break;
      end
      if (busy) busy_cnt++;
    end
    o_bcd = bcd;
    o_blank = blank;
    o_ovf = overflow;
  endtask

  task automatic test_reset();
    bit seen_done;
    logic [15:0] b; logic [3:0] bl; logic o; int lat, bc; bit to;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== 16'h0000 || blank !== 4'b1110 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_init: busy=%b done=%b bcd=%h blank=%b ovf=%b, want 0 0 0000 1110 0", busy, done, bcd, blank, overflow);
    end
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    bin = 14'd1234;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== 16'h0000 || blank !== 4'b1110 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b bcd=%h blank=%b ovf=%b, want 0 0 0000 1110 0", busy, done, bcd, blank, overflow);
    end
    seen_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    n_checks++;
    if (seen_done || bcd !== 16'h0000 || blank !== 4'b1110) begin
      n_fail++;
      $display("FAIL reset_abort: activity=%b bcd=%h blank=%b, want 0 0000 1110", seen_done, bcd, blank);
    end
    run_conv(1234, b, bl, o, lat, bc, to);
    n_checks++;
    if (to || b !== 16'h1234 || bl !== 4'b0000 || o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_restart: timeout=%b bcd=%h blank=%b ovf=%b, want 0 1234 0000 0", to, b, bl, o);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [15:0] b; logic [3:0] bl; logic o; int lat, bc; bit to;
    run_conv(1234, b, bl, o, lat, bc, to);
    n_checks++;
    if (to || lat != BIN_W) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d (timeout=%b), want %0d", lat, to, BIN_W);
    end
    n_checks++;
    if (bc != BIN_W) begin
      n_fail++;
      $display("FAIL basic_busy_cycles: got %0d, want %0d", bc, BIN_W);
    end
    n_checks++;
    if (b !== 16'h1234 || bl !== 4'b0000 || o !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: bcd=%h blank=%b ovf=%b, want 1234 0000 0", b, bl, o);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || bcd !== 16'h1234) begin
      n_fail++;
      $display("FAIL basic_done_width: done=%b bcd=%h, want 0 1234", done, bcd);
    end
    $display("basic: bin=1234 bcd=%h blank=%b ovf=%b latency=%0d", b, bl, o, lat);
  endtask

  task automatic test_values();
    int vals[6] = '{0, 7, 305, 9999, 10000, 16383};
    logic [15:0] b; logic [3:0] bl; logic o; int lat, bc; bit to;
    foreach (vals[k]) begin
      run_conv(vals[k], b, bl, o, lat, bc, to);
      n_checks++;
      if (to || lat != BIN_W || b !== ref_bcd(vals[k]) || bl !== ref_blank(vals[k]) || o !== ref_ovf(vals[k])) begin
        n_fail++;
        $display("FAIL value_%0d: bcd=%h blank=%b ovf=%b lat=%0d, want %h %b %b %0d",
                 vals[k], b, bl, o, lat, ref_bcd(vals[k]), ref_blank(vals[k]), ref_ovf(vals[k]), BIN_W);
      end
      $display("value: bin=%0d bcd=%h blank=%b ovf=%b", vals[k], b, bl, o);
      @(negedge clk);
    end
  endtask

  task automatic test_ignore_start();
    int c;
    bit got;
    start = 1'b1;
    bin = 14'd1234;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    bin = 14'd0;
    c = 0;
    got = 1'b0;
    while (c < 40 && !got) begin
      @(posedge clk);
      @(negedge clk);
      c++;
      if (done) got = 1'b1;
      else begin
        start = (c == 3 || c == 10);
        bin = (c == 3 || c == 10) ? 14'd4321 : 14'($urandom);
      end
    end
    start = 1'b0;
    n_checks++;
    if (!got || c != BIN_W || bcd !== 16'h1234 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_start: done=%b cycles=%0d bcd=%h ovf=%b, want 1 %0d 1234 0", got, c, bcd, overflow, BIN_W);
    end
    repeat (BIN_W + 2) begin
      @(negedge clk);
      if (busy || done) got = 1'b0;
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL ignore_no_queue: extra conversion seen, want none");
    end
    $display("ignore: bcd=%h after starts at cycles 3 and 10", bcd);
  endtask

  task automatic test_back_to_back(input int n, input bit rnd);
    int exp_q[$];
    int issued, got, v, e, cyc;
    logic [15:0] last_bcd;
    bit prev_done;
    v = rnd ? rand_val() : 0;
    exp_q.push_back(v);
    issued = 1;
    bin = 14'(v);
    start = 1'b1;
    got = 0;
    cyc = 0;
    last_bcd = bcd;
    prev_done = 1'b0;
    while (got < n && cyc < n * (BIN_W + 1) + 50) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (done) begin
        e = exp_q.pop_front();
        n_checks++;
        if (bcd !== ref_bcd(e) || blank !== ref_blank(e) || overflow !== ref_ovf(e)) begin
          n_fail++;
          $display("FAIL b2b_result bin=%0d: bcd=%h blank=%b ovf=%b, want %h %b %b",
                   e, bcd, blank, overflow, ref_bcd(e), ref_blank(e), ref_ovf(e));
        end
        if (!rnd) $display("b2b: bin=%0d bcd=%h blank=%b ovf=%b", e, bcd, blank, overflow);
        got++;
        last_bcd = bcd;
        if (issued < n) begin
          v = rnd ? rand_val() : issued;
          bin = 14'(v);
          exp_q.push_back(v);
          issued++;
        end else begin
          start = 1'b0;
        end
      end else begin
        n_checks++;
        if (bcd !== last_bcd || (prev_done && got < n && !busy)) begin
          n_fail++;
          $display("FAIL b2b_hold: bcd=%h busy=%b, want %h busy after done", bcd, busy, last_bcd);
        end
      end
      prev_done = done;
    end
    start = 1'b0;
    n_checks++;
    if (got != n) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results, want %0d", got, n);
    end
    if (rnd) $display("sweep: %0d random conversions compared", got);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_ignore_start();
    test_back_to_back(6, 1'b0);
    test_back_to_back(500, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
